ahb_mem_slave: RTL

- Bus-responder end of the interconnect: a single AHB-lite style word-wide memory slave.
- Sits behind one decoder select line. Consumes the shared address bus (16 bit), write data bus (32 bit) and the bus-level ready.
- Returns read data, ready and 2-bit response. These feed one leg of the interconnect's read-data/response mux.
- Handles pipelined address/data phases, programmable wait states and two-cycle ERROR responses.

---
 rtl/ahb_mem_slave.sv | 114 +++++++++++
 1 files changed

// File: rtl/ahb_mem_slave.sv
// Word-wide AHB-lite memory slave with programmable wait states.
// Misaligned and out-of-range accesses get the two-cycle ERROR response.
module ahb_mem_slave #(
    parameter int MEM_WORDS   = 256,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        hsel,
    input  logic [15:0] haddr,
    input  logic        hwrite,
    input  logic [1:0]  htrans,
    input  logic        hready_in,
    input  logic [31:0] hwdata,
    output logic [31:0] hrdata,
    output logic        hreadyout,
    output logic [1:0]  hresp
);

    localparam int IDX_W = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
    localparam logic [3:0] WS_LOAD = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;
    localparam logic [1:0] RESP_OKAY  = 2'b00;
    localparam logic [1:0] RESP_ERROR = 2'b01;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_DATA,
        ST_ERR1,
        ST_ERR2
    } state_t;

    state_t             state_reg, state_next;
    logic [3:0]         wait_cnt_reg, wait_cnt_next;
    logic [IDX_W-1:0]   idx_reg;
    logic               write_reg;
    logic               hreadyout_reg;
    logic [1:0]         hresp_reg;
    logic               accept;
    logic               addr_err;
    logic               unused_htrans0;

    logic [31:0] mem [MEM_WORDS];

    assign unused_htrans0 = htrans[0];

    // Only states that drive hreadyout high can take a new address phase.
    assign accept = hsel && htrans[1] && hready_in &&
                    ((state_reg == ST_IDLE) || (state_reg == ST_DATA) || (state_reg == ST_ERR2));

    assign addr_err = (haddr[1:0] != 2'b00) || (32'(haddr[15:2]) >= MEM_WORDS);

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        case (state_reg)
            ST_WAIT: begin
                if (wait_cnt_reg == 4'd0) begin
                    state_next = ST_DATA;
                end else begin
                    wait_cnt_next = wait_cnt_reg - 4'd1;
                end
            end
            ST_ERR1: state_next = ST_ERR2;
            default: begin
                if (accept) begin
                    if (addr_err) begin
                        state_next = ST_ERR1;
                    end else if (WAIT_STATES > 0) begin
                        state_next    = ST_WAIT;
                        wait_cnt_next = WS_LOAD;
                    end else begin
                        state_next = ST_DATA;
                    end
                end else begin
                    state_next = ST_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg     <= ST_IDLE;
            wait_cnt_reg  <= 4'd0;
            idx_reg       <= '0;
            write_reg     <= 1'b0;
            hreadyout_reg <= 1'b1;
            hresp_reg     <= RESP_OKAY;
        end else begin
            state_reg     <= state_next;
            wait_cnt_reg  <= wait_cnt_next;
            if (accept) begin
                idx_reg   <= haddr[IDX_W+1:2];
                write_reg <= hwrite;
            end
            hreadyout_reg <= !((state_next == ST_WAIT) || (state_next == ST_ERR1));
            hresp_reg     <= ((state_next == ST_ERR1) || (state_next == ST_ERR2)) ? RESP_ERROR
                                                                                  : RESP_OKAY;
        end
    end

    // No reset on the array: contents survive rst, and reset forces IDLE so no write can fire.
    always_ff @(posedge clk) begin
        if ((state_reg == ST_DATA) && write_reg) begin
            mem[idx_reg] <= hwdata;
        end
    end

    assign hrdata    = ((state_reg == ST_DATA) && !write_reg) ? mem[idx_reg] : 32'd0;
    assign hreadyout = hreadyout_reg;
    assign hresp     = hresp_reg;

endmodule
